systolic_feed_ctrl: RTL

- Sequences one operand tile into the systolic array's diagonal skew buffer (lane n delayed n+1 cycles).
- On start it issues a run of row reads to the operand SRAM and gates returned row data onto the skew-buffer input, zero when idle.
- It produces a per-lane valid mask aligned with the skewed data, and pulses done once the last row has left the deepest lane.
- Sits between the tile scheduler (start/config) and the skew buffer plus array (data/valid).

---
 rtl/systolic_feed_ctrl_pkg.sv | 8 +
 rtl/register_sync.sv | 12 +
 rtl/systolic_feed_ctrl_valid_skew_chain.sv | 21 ++
 rtl/systolic_feed_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// systolic_feed_ctrl_pkg: FSM encoding and width helpers shared by the operand feed controller.
package systolic_feed_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
  localparam int ROW_WIDTH_DEF = 16;
  function automatic int drain_width(input int rd_lat, input int array);
    return $clog2(rd_lat + array + 1);
  endfunction
endpackage

// File: rtl/register_sync.sv
// register_sync: plain register with asynchronous active-high clear.
module register_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    q <= reset ? '0 : d;
endmodule

// File: rtl/systolic_feed_ctrl_valid_skew_chain.sv
// systolic_feed_ctrl_valid_skew_chain: 1-bit delay chain, tap n is d delayed n+1 cycles.
module systolic_feed_ctrl_valid_skew_chain #(
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  output logic [DEPTH-1:0] taps
);
  logic [DEPTH:0] chain;
  assign chain[0] = d;
  assign taps = chain[DEPTH:1];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    register_sync #(.WIDTH(1)) u_reg (
      .clk  (clk),
      .reset(reset),
      .d    (chain[g]),
      .q    (chain[g+1])
    );
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: streams one operand tile from SRAM into the diagonal skew buffer
// with zero-gated data, per-lane valid mask and a completion pulse once the deepest lane drains.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY          = 32,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY,
  parameter int ADDR_WIDTH     = 16,
  parameter int ROW_WIDTH      = ROW_WIDTH_DEF,
  parameter int RD_LAT         = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]     cfg_stride,
  input  logic [ROW_WIDTH-1:0]      cfg_num_rows,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic [MEM_DATA_WIDTH-1:0] feed_data,
  output logic                      feed_valid,
  output logic [ARRAY-1:0]          lane_valid
);
  localparam int DW = drain_width(RD_LAT, ARRAY);
  state_t                state;
  logic [ADDR_WIDTH-1:0] stride;
  logic [ROW_WIDTH-1:0]  rows_left;
  logic [DW-1:0]         cnt;
  logic [RD_LAT-1:0]     rd_taps;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      stride      <= '0;
      rows_left   <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          stride      <= cfg_stride;
          mem_rd_addr <= cfg_base_addr;
          rows_left   <= cfg_num_rows;
          busy        <= 1'b1;
          mem_rd_en   <= cfg_num_rows != '0;
          state       <= cfg_num_rows != '0 ? FETCH : FIN;
        end
        FETCH: if (rows_left == ROW_WIDTH'(1)) begin
          state     <= DRAIN;
          mem_rd_en <= 1'b0;
          cnt       <= DW'(RD_LAT + ARRAY);
        end else begin
          rows_left   <= rows_left - 1'b1;
          mem_rd_addr <= mem_rd_addr + stride;
        end
        // last row needs RD_LAT cycles to return plus ARRAY cycles to leave the deepest lane
        DRAIN: if (cnt == DW'(1)) begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        // a zero-row tile enters with done low and spends one extra cycle here
        FIN: if (done) begin
          done  <= 1'b0;
          state <= IDLE;
        end else begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  systolic_feed_ctrl_valid_skew_chain #(.DEPTH(RD_LAT)) u_rd_chain (
    .clk  (clk),
    .reset(reset),
    .d    (mem_rd_en),
    .taps (rd_taps)
  );
  assign feed_valid = rd_taps[RD_LAT-1];
  assign feed_data  = feed_valid ? mem_rd_data : '0;
  systolic_feed_ctrl_valid_skew_chain #(.DEPTH(ARRAY)) u_lane_chain (
    .clk  (clk),
    .reset(reset),
    .d    (feed_valid),
    .taps (lane_valid)
  );
endmodule
